// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state enum.
// Commands are encoded as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_SREF  = 3'd2,
    ARB_AREF  = 3'd3,
    ARB_WRITE = 3'd4,
    ARB_READ  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Registered SDRAM pin driver: selects the bus owned by the current arbiter
// state and registers it onto the pins with one cycle of latency.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_state,
  input  logic [3:0]        i_init_cmd,
  input  logic [BA_W-1:0]   i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic              i_sref_cke,
  input  logic [3:0]        i_sref_cmd,
  input  logic [BA_W-1:0]   i_sref_ba,
  input  logic [ADDR_W-1:0] i_sref_addr,
  input  logic [3:0]        i_aref_cmd,
  input  logic [BA_W-1:0]   i_aref_ba,
  input  logic [ADDR_W-1:0] i_aref_addr,
  input  logic [3:0]        i_wr_cmd,
  input  logic [BA_W-1:0]   i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [3:0]        i_rd_cmd,
  input  logic [BA_W-1:0]   i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_cke,
  output logic [3:0]        o_cmd,
  output logic [BA_W-1:0]   o_ba,
  output logic [ADDR_W-1:0] o_addr
);

  arb_state_e        w_state;
  logic              w_cke;
  logic [3:0]        w_cmd;
  logic [BA_W-1:0]   w_ba;
  logic [ADDR_W-1:0] w_addr;

  logic              r_cke;
  logic [3:0]        r_cmd;
  logic [BA_W-1:0]   r_ba;
  logic [ADDR_W-1:0] r_addr;

  assign w_state = arb_state_e'(i_state);

  // Idle (and any unused encoding) parks the pins on NOP with CKE high.
  always_comb begin
    w_cke  = 1'b1;
    w_cmd  = CMD_NOP;
    w_ba   = '1;
    w_addr = '1;
    case (w_state)
      ARB_INIT: begin
        w_cmd  = i_init_cmd;
        w_ba   = i_init_ba;
        w_addr = i_init_addr;
      end
      ARB_SREF: begin
        w_cke  = i_sref_cke;
        w_cmd  = i_sref_cmd;
        w_ba   = i_sref_ba;
        w_addr = i_sref_addr;
      end
      ARB_AREF: begin
        w_cmd  = i_aref_cmd;
        w_ba   = i_aref_ba;
        w_addr = i_aref_addr;
      end
      ARB_WRITE: begin
        w_cmd  = i_wr_cmd;
        w_ba   = i_wr_ba;
        w_addr = i_wr_addr;
      end
      ARB_READ: begin
        w_cmd  = i_rd_cmd;
        w_ba   = i_rd_ba;
        w_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cke  <= 1'b1;
      r_cmd  <= CMD_NOP;
      r_ba   <= '1;
      r_addr <= '1;
    end else begin
      r_cke  <= w_cke;
      r_cmd  <= w_cmd;
      r_ba   <= w_ba;
      r_addr <= w_addr;
    end
  end

  assign o_cke  = r_cke;
  assign o_cmd  = r_cmd;
  assign o_ba   = r_ba;
  assign o_addr = r_addr;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: fixed-priority ownership of the SDRAM pins among
// init, self-refresh, auto-refresh, write and read stages.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              sref_req,
  input  logic              sref_done,
  input  logic              sref_cke,
  input  logic [3:0]        sref_cmd,
  input  logic [BA_W-1:0]   sref_ba,
  input  logic [ADDR_W-1:0] sref_addr,
  input  logic              aref_req,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              aref_end,
  input  logic              wr_end,
  input  logic              rd_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              sref_en,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  arb_state_e r_state;
  arb_state_e w_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_next = r_state;
    if (!init_end && r_state != ARB_INIT) begin
      w_next = ARB_INIT;
    end else begin
      case (r_state)
        ARB_INIT:  if (init_end) w_next = ARB_IDLE;
        ARB_IDLE: begin
          if (sref_req)      w_next = ARB_SREF;
          else if (aref_req) w_next = ARB_AREF;
          else if (wr_req)   w_next = ARB_WRITE;
          else if (rd_req)   w_next = ARB_READ;
        end
        // Only the owner's completion pulse is looked at; others are stray.
        ARB_SREF:  if (sref_done) w_next = ARB_IDLE;
        ARB_AREF:  if (aref_end)  w_next = ARB_IDLE;
        ARB_WRITE: if (wr_end)    w_next = ARB_IDLE;
        ARB_READ:  if (rd_end)    w_next = ARB_IDLE;
        default:   w_next = ARB_INIT;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (sys_rst) r_state <= ARB_INIT;
    else         r_state <= w_next;
  end

  // Grants decode the state register directly; sref_en also tracks the host level.
  assign sref_en = (r_state == ARB_SREF) && sref_req;
  assign aref_en = (r_state == ARB_AREF);
  assign wr_en   = (r_state == ARB_WRITE);
  assign rd_en   = (r_state == ARB_READ);

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W)
  ) u_cmd_mux (
    .i_clk       (sys_clk),
    .i_rst       (sys_rst),
    .i_state     (r_state),
    .i_init_cmd  (init_cmd),
    .i_init_ba   (init_ba),
    .i_init_addr (init_addr),
    .i_sref_cke  (sref_cke),
    .i_sref_cmd  (sref_cmd),
    .i_sref_ba   (sref_ba),
    .i_sref_addr (sref_addr),
    .i_aref_cmd  (aref_cmd),
    .i_aref_ba   (aref_ba),
    .i_aref_addr (aref_addr),
    .i_wr_cmd    (wr_cmd),
    .i_wr_ba     (wr_ba),
    .i_wr_addr   (wr_addr),
    .i_rd_cmd    (rd_cmd),
    .i_rd_ba     (rd_ba),
    .i_rd_addr   (rd_addr),
    .o_cke       (sdram_cke),
    .o_cmd       (sdram_cmd),
    .o_ba        (sdram_ba),
    .o_addr      (sdram_addr)
  );

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: expected pin/grant snapshots are
// queued as stimulus is driven and compared per scenario.
module tb_sdram_cmd_arbiter;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AREF_C = 4'b0001;

  // Grant vector order: {sref_en, aref_en, wr_en, rd_en}
  localparam logic [3:0] G_NONE = 4'b0000;
  localparam logic [3:0] G_SREF = 4'b1000;
  localparam logic [3:0] G_AREF = 4'b0100;
  localparam logic [3:0] G_WR   = 4'b0010;
  localparam logic [3:0] G_RD   = 4'b0001;

  // Bus snapshots {cmd, ba, addr}
  localparam logic [17:0] B_NOP  = {NOP,     2'b11, 12'hFFF};
  localparam logic [17:0] B_INIT = {PRE,     2'b00, 12'h400};
  localparam logic [17:0] B_SREF = {AREF_C,  2'b01, 12'h111};
  localparam logic [17:0] B_AREF = {AREF_C,  2'b10, 12'h222};
  localparam logic [17:0] B_WR   = {4'b0100, 2'b11, 12'h333};
  localparam logic [17:0] B_RD   = {4'b0101, 2'b01, 12'h0A5};

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [11:0] init_addr;
  logic        sref_req, sref_done, sref_cke;
  logic [3:0]  sref_cmd;
  logic [1:0]  sref_ba;
  logic [11:0] sref_addr;
  logic        aref_req, wr_req, rd_req;
  logic        aref_end, wr_end, rd_end;
  logic [3:0]  aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  aref_ba, wr_ba, rd_ba;
  logic [11:0] aref_addr, wr_addr, rd_addr;
  logic        sref_en, aref_en, wr_en, rd_en;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;

  typedef struct {
    logic [22:0] v;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [22:0] got_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_cmd_arbiter #(.ADDR_W(12), .BA_W(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .init_end   (init_end),
    .init_cmd   (init_cmd),
    .init_ba    (init_ba),
    .init_addr  (init_addr),
    .sref_req   (sref_req),
    .sref_done  (sref_done),
    .sref_cke   (sref_cke),
    .sref_cmd   (sref_cmd),
    .sref_ba    (sref_ba),
    .sref_addr  (sref_addr),
    .aref_req   (aref_req),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .aref_end   (aref_end),
    .wr_end     (wr_end),
    .rd_end     (rd_end),
    .aref_cmd   (aref_cmd),
    .aref_ba    (aref_ba),
    .aref_addr  (aref_addr),
    .wr_cmd     (wr_cmd),
    .wr_ba      (wr_ba),
    .wr_addr    (wr_addr),
    .rd_cmd     (rd_cmd),
    .rd_ba      (rd_ba),
    .rd_addr    (rd_addr),
    .sref_en    (sref_en),
    .aref_en    (aref_en),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .sdram_cke  (sdram_cke),
    .sdram_cmd  (sdram_cmd),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr)
  );

  function automatic logic [22:0] mk(input logic [3:0] g, input logic cke, input logic [17:0] bus);
    return {g, cke, bus};
  endfunction

  function automatic logic [22:0] obs();
    return {sref_en, aref_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_ba, sdram_addr};
  endfunction

  // Queue an expectation, then record what the DUT shows right now.
  task automatic sample(input logic [22:0] exp, input string name);
    sb.push_back('{exp, name});
    got_q.push_back(obs());
  endtask

  // One clock: outputs are sampled on the falling edge after the rising edge.
  task automatic step(input logic [22:0] exp, input string name);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sample(exp, name);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [22:0] g;
    sys_rst = 1'b1;
    step(mk(G_NONE, 1'b1, B_NOP), "reset_a");
    step(mk(G_NONE, 1'b1, B_NOP), "reset_b");
    sys_rst = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_init();
    exp_t e;
    logic [22:0] g;
    step(mk(G_NONE, 1'b1, B_INIT), "init_precharge");
    init_end = 1'b1;
    step(mk(G_NONE, 1'b1, B_INIT), "init_exit");
    step(mk(G_NONE, 1'b1, B_NOP), "idle_nop");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [22:0] g;
    sref_req = 1'b1; aref_req = 1'b1; wr_req = 1'b1; sref_cke = 1'b1;
    step(mk(G_SREF, 1'b1, B_NOP), "prio_sref_grant");
    step(mk(G_SREF, 1'b1, B_SREF), "prio_sref_bus");
    sref_done = 1'b1; sref_req = 1'b0;
    step(mk(G_NONE, 1'b1, B_SREF), "prio_idle_gap");
    sref_done = 1'b0;
    step(mk(G_AREF, 1'b1, B_NOP), "prio_aref_grant");
    step(mk(G_AREF, 1'b1, B_AREF), "prio_aref_bus");
    aref_end = 1'b1; aref_req = 1'b0;
    step(mk(G_NONE, 1'b1, B_AREF), "prio_aref_done");
    aref_end = 1'b0;
    step(mk(G_WR, 1'b1, B_NOP), "prio_wr_grant");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [22:0] g;
    step(mk(G_WR, 1'b1, B_WR), "b2b_wr_bus");
    wr_end = 1'b1; wr_req = 1'b0; rd_req = 1'b1;
    step(mk(G_NONE, 1'b1, B_WR), "b2b_idle");
    wr_end = 1'b0;
    step(mk(G_RD, 1'b1, B_NOP), "b2b_rd_grant");
    step(mk(G_RD, 1'b1, B_RD), "b2b_rd_bus");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_stray_pulses();
    exp_t e;
    logic [22:0] g;
    aref_end = 1'b1; sref_done = 1'b1; wr_end = 1'b1;
    step(mk(G_RD, 1'b1, B_RD), "stray_ignored");
    aref_end = 1'b0; sref_done = 1'b0; wr_end = 1'b0;
    rd_end = 1'b1; rd_req = 1'b0;
    step(mk(G_NONE, 1'b1, B_RD), "rd_done");
    rd_end = 1'b0;
    step(mk(G_NONE, 1'b1, B_NOP), "rd_idle");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_self_refresh();
    exp_t e;
    logic [22:0] g;
    sref_req = 1'b1; sref_cke = 1'b1;
    step(mk(G_SREF, 1'b1, B_NOP), "sref_grant");
    sref_cke = 1'b0;
    step(mk(G_SREF, 1'b0, B_SREF), "sref_cke_low");
    sref_req = 1'b0;
    #1;
    sample(mk(G_NONE, 1'b0, B_SREF), "sref_en_follows_req");
    step(mk(G_NONE, 1'b0, B_SREF), "sref_hold_a");
    step(mk(G_NONE, 1'b0, B_SREF), "sref_hold_b");
    sref_done = 1'b1;
    step(mk(G_NONE, 1'b0, B_SREF), "sref_exit");
    sref_done = 1'b0;
    step(mk(G_NONE, 1'b1, B_NOP), "sref_cke_high");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_init_abort();
    exp_t e;
    logic [22:0] g;
    rd_req = 1'b1;
    step(mk(G_RD, 1'b1, B_NOP), "abort_rd_grant");
    init_end = 1'b0;
    step(mk(G_NONE, 1'b1, B_RD), "abort_drop");
    step(mk(G_NONE, 1'b1, B_INIT), "abort_in_init");
    rd_req = 1'b0; init_end = 1'b1;
    step(mk(G_NONE, 1'b1, B_INIT), "abort_reinit_exit");
    step(mk(G_NONE, 1'b1, B_NOP), "abort_idle");
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    logic [22:0] g;
    wr_req = 1'b1;
    step(mk(G_WR, 1'b1, B_NOP), "rstw_grant");
    step(mk(G_WR, 1'b1, B_WR), "rstw_bus");
    #2;
    sys_rst = 1'b1;
    #1;
    sample(mk(G_NONE, 1'b1, B_NOP), "rstw_async");
    @(negedge sys_clk);
    init_end = 1'b0;
    sys_rst  = 1'b0;
    step(mk(G_NONE, 1'b1, B_INIT), "rstw_back_in_init");
    wr_req = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e.v) begin bad++; $display("FAIL %s got=%06h want=%06h", e.name, g, e.v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    init_end = 1'b0;
    {init_cmd, init_ba, init_addr} = B_INIT;
    {sref_cmd, sref_ba, sref_addr} = B_SREF;
    {aref_cmd, aref_ba, aref_addr} = B_AREF;
    {wr_cmd, wr_ba, wr_addr}       = B_WR;
    {rd_cmd, rd_ba, rd_addr}       = B_RD;
    sref_req = 1'b0; sref_done = 1'b0; sref_cke = 1'b1;
    aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_init();
    test_priority();
    test_back_to_back();
    test_stray_pulses();
    test_self_refresh();
    test_init_abort();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning SDRAM address width.
REQ-002 SHALL have parameter BA_W, default 2, meaning bank-address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports follow.
REQ-004 sys_clk  in  1  system clock, all logic on the rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 init_end  in  1  level; high once power-up initialisation is complete.
REQ-007 init_cmd/init_ba/init_addr  in  4/BA_W/ADDR_W  initialisation source bus.
REQ-008 sref_req  in  1  host self-refresh request, level.
REQ-009 sref_done  in  1  one-cycle pulse from the self-refresh stage when its exit completes.
REQ-010 sref_cke/sref_cmd/sref_ba/sref_addr  in  1/4/BA_W/ADDR_W  self-refresh source bus.
REQ-011 aref_req, wr_req, rd_req  in  1 each  request levels from the auto-refresh, write and read stages.
REQ-012 aref_end, wr_end, rd_end  in  1 each  one-cycle completion pulses from those stages.
REQ-013 aref_cmd/ba/addr, wr_cmd/ba/addr, rd_cmd/ba/addr  in  4/BA_W/ADDR_W  source buses.
REQ-014 sref_en, aref_en, wr_en, rd_en  out  1 each  grants; at most one high at any time.
REQ-015 sdram_cke/sdram_cmd/sdram_ba/sdram_addr  out  1/4/BA_W/ADDR_W  registered SDRAM pins.

Function
REQ-016 The FSM SHALL have states ARB_INIT, ARB_IDLE, ARB_SREF, ARB_AREF, ARB_WRITE and ARB_READ.
REQ-017 ARB_INIT: route the init bus to the outputs; move to ARB_IDLE on the first cycle init_end is high.
REQ-018 ARB_IDLE: grant by fixed priority sref_req > aref_req > wr_req > rd_req, entering the matching state on the next edge.
REQ-019 A grant SHALL be asserted combinationally from the state register, so it is high from the first cycle in the granted state.
REQ-020 ARB_SREF: sref_en SHALL follow sref_req; return to ARB_IDLE on sref_done; sref_req falling alone SHALL NOT leave the state.
REQ-021 ARB_AREF, ARB_WRITE, ARB_READ: hold the state until the matching *_end pulse, then return to ARB_IDLE.
REQ-022 A *_end pulse and a new request in the same cycle SHALL produce exactly one ARB_IDLE cycle before the next grant.
REQ-023 Requests SHALL be sampled only in ARB_IDLE; a request arriving during another grant SHALL wait and SHALL NOT be lost while it stays high.
REQ-024 *_end or sref_done pulses from a non-granted source SHALL be ignored.
REQ-025 In each granted state the owner's cmd/ba/addr SHALL be registered onto sdram_*, one-cycle latency.
REQ-026 In ARB_IDLE: sdram_cmd=NOP (4'b0111), sdram_ba all ones, sdram_addr all ones.
REQ-027 sdram_cke SHALL equal the registered sref_cke in ARB_SREF, and 1 in every other state.
REQ-028 If init_end falls outside ARB_INIT, the FSM SHALL abort to ARB_INIT on the next edge and drop all grants.

Reset
REQ-029 Reset SHALL force state=ARB_INIT, all grants 0, sdram_cke=1, sdram_cmd=NOP, sdram_ba all ones, sdram_addr all ones.
REQ-030 Reset asserted mid-grant SHALL take effect asynchronously, without waiting for a completion pulse.

Structure
REQ-031 Command encodings (NOP, PRECHARGE, AUTO_REF) and the FSM state enum SHALL live in shared package sdram_pkg.
REQ-032 The output register and mux SHALL be a sub-module sdram_cmd_mux; the FSM stays in the top level.

Verification
REQ-033 Init: init_end=0, init_cmd=PRECHARGE -> sdram_cmd=PRECHARGE one cycle later; init_end=1 -> ARB_IDLE and sdram_cmd=NOP.
REQ-034 Priority: sref_req, aref_req and wr_req all high in ARB_IDLE -> sref_en only; aref_en only after sref_done plus one IDLE cycle.
REQ-035 Self-refresh: sref_cke=0 in ARB_SREF -> sdram_cke=0 one cycle later; drop sref_req -> sref_en=0, state held until sref_done, then sdram_cke=1.
REQ-036 Back-to-back: wr_end in the same cycle as a rising rd_req -> wr_en low, one NOP cycle, rd_en high.
REQ-037 Reset mid-ARB_WRITE, with wr_cmd=4'b0100 driven -> same cycle: wr_en=0, sdram_cmd=NOP, sdram_cke=1; after release, state=ARB_INIT.
REQ-038 Stray pulses: aref_end asserted during ARB_READ -> rd_en stays high and the state is unchanged.
